siso_frame_ctrl: RTL and testbench

//  Sequencer for a serial-in/serial-out shift datapath: accepts a parallel word over a

---
 rtl/siso_frame_ctrl_pkg.sv | 23 ++
 rtl/siso_frame_ctrl_bit_tick_gen.sv | 43 ++++
 rtl/siso_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_siso_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_frame_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// siso_frame_ctrl_pkg
// Shared definitions for the SISO frame controller: the sequencer state
// encoding and a width helper for the bit-period and bit counters.
// No ports (package).
// ----------------------------------------------------------------------------
package siso_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter width for a counter that must hold values 0..n-1, never below 1.
    function automatic int cnt_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/siso_frame_ctrl_bit_tick_gen.sv
// ----------------------------------------------------------------------------
// bit_tick_gen
// Bit-period timer. While en is high it counts clocks and pulses tick on the
// last clock of every DIV-clock period; with DIV=1 tick follows en directly.
// The count is held at zero whenever en is low, so each frame starts with a
// full-length first bit period.
// Ports:
//   clk    in   clock, posedge
//   rst_n  in   synchronous active-low reset
//   en     in   count enable (high while a frame is shifting)
//   tick   out  end of the current bit period
// ----------------------------------------------------------------------------
module bit_tick_gen
    import siso_frame_ctrl_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int            DW   = cnt_w(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          w_last;

    assign w_last = (r_div_cnt == LAST);
    assign tick   = en & w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (!en || w_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/siso_frame_ctrl.sv
// ----------------------------------------------------------------------------
// siso_frame_ctrl
// Sequencer for a serial-in/serial-out shift datapath. A parallel word is
// accepted over a valid/ready handshake and shifted out one bit per bit
// period on sout, followed by a one-cycle done pulse.
// Parameters:
//   WIDTH      data bits per frame (>= 2)
//   DIV        clocks per bit period (>= 1)
//   MSB_FIRST  0: bit 0 leaves first, 1: bit WIDTH-1 leaves first
// Ports:
//   clk       in   clock, posedge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   producer has a word on in_data
//   in_ready  out  controller accepts a word this cycle (IDLE only)
//   in_data   in   parallel word, sampled on accept
//   sout      out  serial data, 0 outside a frame
//   sout_en   out  sout carries a frame bit
//   busy      out  frame in progress (SHIFT and DONE)
//   done      out  one-cycle pulse after the last bit period
// ----------------------------------------------------------------------------
module siso_frame_ctrl
    import siso_frame_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sout,
    output logic             sout_en,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = cnt_w(WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sreg;
    logic [BW-1:0]    r_bit_cnt;
    logic             w_shift_en;
    logic             w_tick;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_sout_bit;

    // Advance the shift register by one bit towards the output end.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0) begin
            return {v[WIDTH-2:0], 1'b0};
        end
        return {1'b0, v[WIDTH-1:1]};
    endfunction

    assign w_shift_en = (r_state == ST_SHIFT);
    assign w_accept   = in_valid & in_ready;
    assign w_last_bit = w_tick & (r_bit_cnt == BIT_LAST);
    assign w_sout_bit = (MSB_FIRST != 0) ? r_sreg[WIDTH-1] : r_sreg[0];

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_shift_en),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and output decode; every output depends on registered state only.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        sout     = 1'b0;
        sout_en  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                sout_en = 1'b1;
                sout    = w_sout_bit;
                if (w_last_bit) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Word is captured only on accept, so later in_data changes cannot
    // disturb a frame already in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_sreg    <= in_data;
            r_bit_cnt <= '0;
        end else if (w_tick) begin
            r_sreg    <= shift_once(r_sreg);
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_siso_frame_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_siso_frame_ctrl
// Three controller instances:
//   a: WIDTH=4, DIV=1, LSB first  -- table-driven vectors
//   b: WIDTH=4, DIV=3, MSB first  -- hand sequence + random vs. reference model
//   c: WIDTH=8, DIV=1, LSB first  -- hand sequences + random vs. reference model
// ----------------------------------------------------------------------------
module tb_siso_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rst_n_a, in_valid_a, in_ready_a, sout_a, sout_en_a, busy_a, done_a;
    logic [3:0] in_data_a;
    logic       rst_n_b, in_valid_b, in_ready_b, sout_b, sout_en_b, busy_b, done_b;
    logic [3:0] in_data_b;
    logic       rst_n_c, in_valid_c, in_ready_c, sout_c, sout_en_c, busy_c, done_c;
    logic [7:0] in_data_c;

    siso_frame_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .sout(sout_a), .sout_en(sout_en_a), .busy(busy_a), .done(done_a)
    );
    siso_frame_ctrl #(.WIDTH(4), .DIV(3), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .sout(sout_b), .sout_en(sout_en_b), .busy(busy_b), .done(done_b)
    );
    siso_frame_ctrl #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_data(in_data_c), .sout(sout_c), .sout_en(sout_en_c), .busy(busy_c), .done(done_c)
    );

    logic [4:0] outs_a, outs_b, outs_c;
    assign outs_a = {in_ready_a, sout_a, sout_en_a, busy_a, done_a};
    assign outs_b = {in_ready_b, sout_b, sout_en_b, busy_b, done_b};
    assign outs_c = {in_ready_c, sout_c, sout_en_c, busy_c, done_c};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs {in_ready, sout, sout_en, busy, done} for cycle c,
    // given the cycle ts whose closing edge accepted the word.
    function automatic logic [4:0] model_out(input int w, input int d, input bit msb,
                                             input bit act, input int ts,
                                             input logic [7:0] data, input int c);
        int dt;
        int k;
        logic b;
        if (!act) return 5'b10000;
        dt = c - ts;
        if (dt >= 1 && dt <= w * d) begin
            k = (dt - 1) / d;
            b = msb ? data[w - 1 - k] : data[k];
            return {1'b0, b, 1'b1, 1'b1, 1'b0};
        end
        if (dt == w * d + 1) return 5'b00011;
        return 5'b10000;
    endfunction

    int         cyc = 0;
    bit         chk_en = 1'b0;
    bit         act_b = 1'b0, act_c = 1'b0;
    int         ts_b = 0, ts_c = 0;
    logic [7:0] dat_b = '0, dat_c = '0;
    logic [4:0] exp_b, exp_c;

    assign exp_b = model_out(4, 3, 1'b1, act_b, ts_b, dat_b, cyc);
    assign exp_c = model_out(8, 1, 1'b0, act_c, ts_c, dat_c, cyc);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n_b) begin
            act_b <= 1'b0;
        end else if (exp_b[4] && in_valid_b) begin
            act_b <= 1'b1;
            ts_b  <= cyc;
            dat_b <= {4'b0, in_data_b};
        end
        if (!rst_n_c) begin
            act_c <= 1'b0;
        end else if (exp_c[4] && in_valid_c) begin
            act_c <= 1'b1;
            ts_c  <= cyc;
            dat_c <= in_data_c;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_b", 32'(outs_b), 32'(exp_b));
            check("model_c", 32'(outs_c), 32'(exp_c));
        end
    end

    typedef struct {
        logic       vld;
        logic [3:0] data;
        logic [4:0] exp;   // {in_ready, sout, sout_en, busy, done}
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        int          bit_cyc[16];
        int          nb, nacc, ndone;
        logic        acc;

        // Frame 4'b1011 then 4'b0110 back to back; valid pulses in SHIFT/DONE are ignored.
        tbl[0]  = '{1'b1, 4'b1011, 5'b10000};
        tbl[1]  = '{1'b0, 4'b0000, 5'b01110};
        tbl[2]  = '{1'b0, 4'b0000, 5'b01110};
        tbl[3]  = '{1'b0, 4'b0000, 5'b00110};
        tbl[4]  = '{1'b0, 4'b0000, 5'b01110};
        tbl[5]  = '{1'b0, 4'b0000, 5'b00011};
        tbl[6]  = '{1'b1, 4'b0110, 5'b10000};
        tbl[7]  = '{1'b0, 4'b0000, 5'b00110};
        tbl[8]  = '{1'b1, 4'b1111, 5'b01110};
        tbl[9]  = '{1'b0, 4'b0000, 5'b01110};
        tbl[10] = '{1'b0, 4'b0000, 5'b00110};
        tbl[11] = '{1'b1, 4'b1111, 5'b00011};
        tbl[12] = '{1'b0, 4'b0000, 5'b10000};
        tbl[13] = '{1'b0, 4'b0000, 5'b10000};

        rst_n_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
        rst_n_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
        rst_n_c = 1'b0; in_valid_c = 1'b0; in_data_c = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        @(negedge clk);
        check("reset_a", 32'(outs_a), 32'(5'b10000));
        check("reset_b", 32'(outs_b), 32'(5'b10000));
        check("reset_c", 32'(outs_c), 32'(5'b10000));
        chk_en = 1'b1;

        // Idle after reset: nothing on the line, no done.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_c", 32'({sout_c, sout_en_c, done_c}), 32'(0));
        end

        // Table-driven vectors on instance a.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            in_valid_a = tbl[i].vld;
            in_data_a  = tbl[i].data;
            @(negedge clk);
            check($sformatf("tbl_a[%0d]", i), 32'(outs_a), 32'(tbl[i].exp));
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;

        // DIV=3, MSB first, 4'b1000: three cycles of 1, nine of 0, done at t+13.
        in_valid_b = 1'b1;
        in_data_b  = 4'b1000;
        @(negedge clk);
        check("t2_ready", 32'(in_ready_b), 32'(1));
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            check($sformatf("t2_cyc%0d", i), 32'({sout_b, sout_en_b, done_b, in_ready_b}),
                  32'({i <= 3, i <= 12, i == 13, i == 14}));
        end

        // in_valid held high: A5 then 3C, exactly two frames with a two-cycle gap.
        @(posedge clk);
        #1;
        in_valid_c = 1'b1;
        in_data_c  = 8'hA5;
        bits = '0; nb = 0; nacc = 0; ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sout_en_c && nb < 16) begin
                bits[nb]    = sout_c;
                bit_cyc[nb] = i;
                nb++;
            end
            if (done_c) ndone++;
            acc = in_ready_c && in_valid_c;
            @(posedge clk);
            #1;
            if (acc) begin
                nacc++;
                if (nacc == 1) in_data_c = 8'h3C;
                else           in_valid_c = 1'b0;
            end
        end
        check("t3_nbits", 32'(nb), 32'(16));
        check("t3_bits", 32'(bits), 32'({8'h3C, 8'hA5}));
        check("t3_gap", 32'(bit_cyc[8] - bit_cyc[7] - 1), 32'(2));
        check("t3_accepts", 32'(nacc), 32'(2));
        check("t3_dones", 32'(ndone), 32'(2));

        // Reset during bit 2 of 8'hFF: frame abandoned, no done.
        in_valid_c = 1'b1;
        in_data_c  = 8'hFF;
        @(negedge clk);
        check("t4_ready", 32'(in_ready_c), 32'(1));
        @(posedge clk);
        #1;
        in_valid_c = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t4_mid", 32'({sout_c, sout_en_c}), 32'(2'b11));
        rst_n_c = 1'b0;
        @(posedge clk);
        #1;
        rst_n_c = 1'b1;
        @(negedge clk);
        check("t4_after", 32'(outs_c), 32'(5'b10000));
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_c) ndone++;
        end
        check("t4_nodone", 32'(ndone), 32'(0));

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            in_valid_b = ($urandom_range(0, 3) != 0);
            in_data_b  = 4'($urandom);
            rst_n_b    = ($urandom_range(0, 79) != 0);
            in_valid_c = ($urandom_range(0, 3) != 0);
            in_data_c  = 8'($urandom);
            rst_n_c    = ($urandom_range(0, 79) != 0);
        end
        @(posedge clk);
        #1;
        in_valid_b = 1'b0; rst_n_b = 1'b1;
        in_valid_c = 1'b0; rst_n_c = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
